pour_sequencer: RTL and testbench

POUR_SEQUENCER -- requirements
Module: pour_sequencer

---
 rtl/cups_pkg.sv | 44 ++++
 rtl/pour_fifo.sv | 43 ++++
 rtl/pour_sequencer.sv | 103 ++++++++++
 tb/tb_pour_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cups_pkg.sv
// Shared cup codes, capacities, goal level and sequencer types.
package cups_pkg;

  typedef enum logic [1:0] {
    CUP_L = 2'd0,
    CUP_M = 2'd1,
    CUP_S = 2'd2,
    CUP_X = 2'd3
  } cup_e;

  localparam logic [3:0] CAP_L    = 4'd12;
  localparam logic [3:0] CAP_M    = 4'd8;
  localparam logic [3:0] CAP_S    = 4'd5;
  localparam logic [3:0] GOAL_LVL = 4'd6;

  typedef enum logic [2:0] {
    IDLE, CHECK, ISSUE, SETTLE0, SETTLE1, HALT
  } seq_state_e;

  typedef struct packed {
    logic [1:0] src;
    logic [1:0] dst;
  } pour_cmd_t;

  function automatic logic [3:0] cup_cap(input logic [1:0] c);
    case (c)
      CUP_L:   return CAP_L;
      CUP_M:   return CAP_M;
      CUP_S:   return CAP_S;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] cup_lvl(input logic [1:0] c, input logic [3:0] l,
                                         input logic [3:0] m, input logic [3:0] s);
    case (c)
      CUP_L:   return l;
      CUP_M:   return m;
      CUP_S:   return s;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/pour_fifo.sv
// Command FIFO: power-of-two depth, wrap-bit pointers, pushes ignored when full.
module pour_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_wdata,
  output logic [W-1:0]             o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_cnt
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] r_mem;
  logic [AW:0]             r_wptr, r_rptr;
  logic                    w_push, w_pop;

  assign o_cnt   = r_wptr - r_rptr;
  assign o_full  = (o_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_wptr == r_rptr);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mem  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr[AW-1:0]] <= i_wdata;
        r_wptr                <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/pour_sequencer.sv
// Buffers pour commands, drops illegal ones against live cup levels, issues legal
// ones as single-cycle pulses and waits out the downstream latch+pour latency.
module pour_sequencer
  import cups_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_from,
  input  logic [1:0]       in_to,
  input  logic [3:0]       lvl_large,
  input  logic [3:0]       lvl_medium,
  input  logic [3:0]       lvl_small,
  input  logic             done_in,
  output logic [1:0]       from,
  output logic [1:0]       to,
  output logic             move_valid,
  output logic [CNT_W-1:0] move_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             halted
);
  localparam int AW = $clog2(DEPTH);

  seq_state_e         r_state, w_nxt;
  pour_cmd_t          r_cmd, w_head;
  logic [CNT_W-1:0]   r_move_cnt, r_drop_cnt;
  logic               w_full, w_empty, w_push, w_pop, w_legal;
  logic [AW:0]        w_cnt;
  logic [3:0]         w_src_lvl, w_dst_lvl;

  assign in_ready = !w_full && (r_state != HALT);
  assign w_push   = in_valid && in_ready;

  pour_fifo #(.DEPTH(DEPTH), .W(4)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({in_from, in_to}),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_cnt   (w_cnt)
  );

  assign w_src_lvl = cup_lvl(w_head.src, lvl_large, lvl_medium, lvl_small);
  assign w_dst_lvl = cup_lvl(w_head.dst, lvl_large, lvl_medium, lvl_small);
  assign w_legal   = (w_head.src != w_head.dst) && (w_head.src != CUP_X) &&
                     (w_head.dst != CUP_X) && (w_src_lvl != 4'd0) &&
                     (w_dst_lvl != cup_cap(w_head.dst));

  always_comb begin
    w_nxt = r_state;
    w_pop = 1'b0;
    case (r_state)
      IDLE:    if (done_in) w_nxt = HALT;
               else if (!w_empty) w_nxt = CHECK;
      // done_in wins over the head: it stays queued
      CHECK:   if (done_in) w_nxt = HALT;
               else if (w_empty) w_nxt = IDLE;
               else begin
                 w_pop = 1'b1;
                 if (w_legal) w_nxt = ISSUE;
                 else if (w_cnt > (AW+1)'(1)) w_nxt = CHECK;
                 else w_nxt = IDLE;
               end
      ISSUE:   w_nxt = done_in ? HALT : SETTLE0;
      SETTLE0: w_nxt = done_in ? HALT : SETTLE1;
      SETTLE1: w_nxt = done_in ? HALT : IDLE;
      HALT:    w_nxt = HALT;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_cmd      <= '0;
      r_move_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_pop && w_legal) begin
        r_cmd <= w_head;
        if (r_move_cnt != {CNT_W{1'b1}}) r_move_cnt <= r_move_cnt + 1'b1;
      end
      if (w_pop && !w_legal && r_drop_cnt != {CNT_W{1'b1}})
        r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign move_valid = (r_state == ISSUE);
  assign from       = move_valid ? r_cmd.src : CUP_L;
  assign to         = move_valid ? r_cmd.dst : CUP_L;
  assign halted     = (r_state == HALT);
  assign move_count = r_move_cnt;
  assign drop_count = r_drop_cnt;

endmodule

// File: tb/tb_pour_sequencer.sv
// Directed bench: a cups model closes the loop on from/to and supplies levels/done.
module tb_pour_sequencer;
  import cups_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 6;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_from = 2'd0, in_to = 2'd0;
  logic [3:0]       lvl_large, lvl_medium, lvl_small;
  logic             done_in;
  logic [1:0]       from, to;
  logic             move_valid, halted;
  logic [CNT_W-1:0] move_count, drop_count;
  logic             force_done = 1'b0;

  int checks = 0;
  int errors = 0;

  pour_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_from    (in_from),
    .in_to      (in_to),
    .lvl_large  (lvl_large),
    .lvl_medium (lvl_medium),
    .lvl_small  (lvl_small),
    .done_in    (done_in),
    .from       (from),
    .to         (to),
    .move_valid (move_valid),
    .move_count (move_count),
    .drop_count (drop_count),
    .halted     (halted)
  );

  always #5 clock = ~clock;

  // Cups model: latch the pour on the pulse, apply it one cycle later.
  logic [3:0] lv [4];
  logic [1:0] m_f, m_t;
  logic       m_pend;
  int         pulses, nop_bad, room, amt;
  logic [1:0] pf [16];
  logic [1:0] pt [16];

  function automatic int cap_of(input logic [1:0] c);
    return (c == 2'd0) ? 12 : (c == 2'd1) ? 8 : (c == 2'd2) ? 5 : 0;
  endfunction

  initial nop_bad = 0;

  always @(negedge clock) begin
    if (!reset_n) begin
      lv[0] = 4'd12; lv[1] = 4'd0; lv[2] = 4'd0; lv[3] = 4'd0;
      m_pend = 1'b0; m_f = 2'd0; m_t = 2'd0; pulses = 0;
    end else begin
      if (m_pend && m_f != 2'd3 && m_t != 2'd3) begin
        room = cap_of(m_t) - int'(lv[m_t]);
        amt  = (int'(lv[m_f]) < room) ? int'(lv[m_f]) : room;
        lv[m_f] = lv[m_f] - 4'(amt);
        lv[m_t] = lv[m_t] + 4'(amt);
      end
      m_pend = 1'b0;
      if (move_valid) begin
        m_f = from; m_t = to; m_pend = 1'b1;
        if (pulses < 16) begin pf[pulses] = from; pt[pulses] = to; end
        pulses++;
      end else if (from != 2'd0 || to != 2'd0) begin
        nop_bad++;
      end
    end
  end

  assign lvl_large  = lv[0];
  assign lvl_medium = lv[1];
  assign lvl_small  = lv[2];
  assign done_in    = force_done || (lv[0] == 4'd6 && lv[1] == 4'd6);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; in_valid = 1'b0; force_done = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push(input logic [1:0] f, input logic [1:0] t);
    int n;
    n = 0;
    @(negedge clock);
    in_valid = 1'b1; in_from = f; in_to = t;
    while (!in_ready && n < 100) begin @(negedge clock); n++; end
    if (!in_ready) chk("push_accept", 32'(in_ready), 1);
    @(posedge clock); #1;
  endtask

  task automatic wait_mv();
    int n;
    n = 0;
    do begin @(negedge clock); n++; end while (!move_valid && n < 50);
  endtask

  initial begin
    int n;
    // reset state
    @(negedge clock);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_move_valid", 32'(move_valid), 0);
    chk("rst_from", 32'(from), 0);
    chk("rst_to", 32'(to), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_move_count", 32'(move_count), 0);
    chk("rst_drop_count", 32'(drop_count), 0);
    @(negedge clock);
    reset_n = 1'b1;

    // 7-move solution to 6/6/0
    push(2'd0, 2'd1); push(2'd1, 2'd2); push(2'd2, 2'd0); push(2'd1, 2'd2);
    push(2'd0, 2'd1); push(2'd1, 2'd2); push(2'd2, 2'd0);
    in_valid = 1'b0;
    n = 0;
    while (!halted && n < 300) begin @(negedge clock); n++; end
    chk("s1_halted", 32'(halted), 1);
    chk("s1_lvl_l", 32'(lvl_large), 6);
    chk("s1_lvl_m", 32'(lvl_medium), 6);
    chk("s1_lvl_s", 32'(lvl_small), 0);
    chk("s1_move_count", 32'(move_count), 7);
    chk("s1_drop_count", 32'(drop_count), 0);
    chk("s1_pulses", 32'(pulses), 7);
    chk("s1_first_pour", {pf[0], pt[0]}, {2'd0, 2'd1});
    chk("s1_last_pour", {pf[6], pt[6]}, {2'd2, 2'd0});
    cyc(5);
    chk("s1_in_ready", 32'(in_ready), 0);
    chk("s1_move_valid", 32'(move_valid), 0);
    chk("s1_pulses_after", 32'(pulses), 7);

    // M>L from an empty medium cup
    do_reset();
    push(2'd1, 2'd0);
    in_valid = 1'b0;
    cyc(10);
    chk("s2_drop_count", 32'(drop_count), 1);
    chk("s2_move_count", 32'(move_count), 0);
    chk("s2_pulses", 32'(pulses), 0);
    chk("s2_lvl_l", 32'(lvl_large), 12);

    // same-cup and invalid-code commands
    do_reset();
    push(2'd0, 2'd0); push(2'd3, 2'd1);
    in_valid = 1'b0;
    cyc(10);
    chk("s3_drop_count", 32'(drop_count), 2);
    chk("s3_pulses", 32'(pulses), 0);
    chk("s3_from", 32'(from), 0);
    chk("s3_to", 32'(to), 0);

    // fill the FIFO while the first pour settles; the sixth offer must bounce
    do_reset();
    @(negedge clock); in_valid = 1'b1; in_from = 2'd0; in_to = 2'd1;
    @(negedge clock); in_from = 2'd2; in_to = 2'd0;
    @(negedge clock); in_from = 2'd1; in_to = 2'd2;
    @(negedge clock); in_from = 2'd2; in_to = 2'd2;
    @(negedge clock); in_from = 2'd0; in_to = 2'd1;
    @(negedge clock);
    chk("s4_in_ready_full", 32'(in_ready), 0);
    chk("s4_pulses_mid", 32'(pulses), 1);
    in_from = 2'd0; in_to = 2'd2;
    @(negedge clock); in_valid = 1'b0;
    cyc(40);
    chk("s4_move_count", 32'(move_count), 3);
    chk("s4_drop_count", 32'(drop_count), 2);
    chk("s4_pulses", 32'(pulses), 3);
    chk("s4_pour2", {pf[1], pt[1]}, {2'd1, 2'd2});
    chk("s4_pour3", {pf[2], pt[2]}, {2'd0, 2'd1});
    chk("s4_lvl_l", 32'(lvl_large), 0);
    chk("s4_lvl_m", 32'(lvl_medium), 7);
    chk("s4_lvl_s", 32'(lvl_small), 5);
    chk("s4_in_ready_end", 32'(in_ready), 1);

    // done_in raised during an ISSUE with two commands queued
    do_reset();
    push(2'd0, 2'd1); push(2'd1, 2'd2); push(2'd2, 2'd0);
    in_valid = 1'b0;
    wait_mv();
    chk("s5_mv_seen", 32'(move_valid), 1);
    force_done = 1'b1;
    @(negedge clock);
    chk("s5_halted", 32'(halted), 1);
    chk("s5_in_ready", 32'(in_ready), 0);
    chk("s5_move_valid", 32'(move_valid), 0);
    force_done = 1'b0;
    cyc(10);
    chk("s5_pulses", 32'(pulses), 1);
    chk("s5_move_count", 32'(move_count), 1);
    chk("s5_drop_count", 32'(drop_count), 0);
    chk("s5_halted_hold", 32'(halted), 1);

    // reset during SETTLE0
    do_reset();
    push(2'd0, 2'd1);
    in_valid = 1'b0;
    wait_mv();
    @(negedge clock);
    chk("s6_pre_move_count", 32'(move_count), 1);
    reset_n = 1'b0;
    #1;
    chk("s6_move_count", 32'(move_count), 0);
    chk("s6_in_ready", 32'(in_ready), 1);
    chk("s6_halted", 32'(halted), 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    cyc(10);
    chk("s6_move_count_after", 32'(move_count), 0);
    chk("s6_drop_count_after", 32'(drop_count), 0);
    chk("s6_pulses_after", 32'(pulses), 0);
    chk("s6_in_ready_after", 32'(in_ready), 1);

    chk("nop_pair_idle", 32'(nop_bad), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
